pcs_rx_sm: RTL and testbench
============================

# pcs_rx_sm

Receive-side PCS state machine for the 1000BASE-X path. Consumes one decoded 8b/10b code-group per enabled cycle from the decoder and produces GMII-style `rxd`/`rx_dv`/`rx_er`, plus the `receiving` status. The carrier-sense block uses `receiving` to drive CRS.

## Interface
- No parameters.
- `clk`  in  1  clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high.
- `sync_status`  in  1  code-group alignment acquired; level.
- `cg_valid`  in  1  one code-group presented this cycle.
- `cg_data`  in  8  decoded octet.
- `cg_is_k`  in  1  code-group is a control (K) character.
- `cg_err`  in  1  invalid code-group or running-disparity error.
- `rxd`  out  8  receive octet.
- `rx_dv`  out  1  receive data valid.
- `rx_er`  out  1  receive error.
- `receiving`  out  1  frame, extension or false carrier in progress.
- `bad_end`  out  1  one-cycle pulse when /T/ is not followed by /R/.

## Operation
- Recognised K codes:
  - K28.5 0xBC (comma).
  - /S/ 0xFB.
  - /T/ 0xFD.
  - /R/ 0xF7.
  - Any other K value counts as "other K".
- States:
  - LINK_FAILED, IDLE, RECEIVE, END_T, END_R, FALSE_CARRIER.
  - EXTEND exists only when the macro in Configuration is defined.
- Loss of sync: `sync_status`=0 in any state sends the block to LINK_FAILED.
  - If the state was RECEIVE, that cycle outputs `rx_dv`=1, `rx_er`=1.
  - Otherwise all outputs are 0.
- LINK_FAILED: outputs 0. Moves to IDLE on a valid K28.5 while `sync_status`=1.
- IDLE: outputs 0; `receiving`=0.
  - D code-groups and K28.5 (idle and /C/ payload) are ignored.
  - /S/ moves to RECEIVE and outputs `rxd`=0x55, `rx_dv`=1.
  - Other K, /T/, /R/ or `cg_err` moves to FALSE_CARRIER.
- FALSE_CARRIER: `rx_er`=1, `rxd`=0x0E, `rx_dv`=0. Returns to IDLE on K28.5.
- RECEIVE:
  - D with no error: `rxd`=`cg_data`, `rx_dv`=1.
  - D with `cg_err`, or other K: `rx_dv`=1, `rx_er`=1, `rxd`=`cg_data`.
  - /T/: `rx_dv`=0, move to END_T.
  - K28.5 (early end): `rx_dv`=1, `rx_er`=1 for that cycle, then IDLE.
- END_T: outputs 0.
  - /R/ moves to END_R.
  - Anything else pulses `bad_end` and goes to IDLE.
- END_R: outputs 0.
  - /R/ stays (alignment padding).
  - K28.5 goes to IDLE.
  - /S/ goes to RECEIVE with SOP output.
  - Anything else goes to IDLE.
- `receiving`=1 in RECEIVE, END_T, END_R, EXTEND and FALSE_CARRIER; 0 elsewhere.
- `cg_valid`=0: state and all outputs hold, except `bad_end`, which is 0.

## Timing
- All outputs are registered: a response appears the cycle after the code-group is sampled with `cg_valid`=1.
- Reset values: state LINK_FAILED; `rxd`=0x00; `rx_dv`, `rx_er`, `receiving`, `bad_end` all 0.
- Reset mid-frame: the next cycle shows all outputs 0, with no error cycle emitted.
- `sync_status` has priority over all code-group decoding.
- `cg_err` has priority over K/D classification, except in LINK_FAILED, where it is ignored.

## Configuration
- `PCS_RX_CARRIER_EXT_EN` defined: in END_R, /R/ moves to EXTEND instead of staying in END_R.
  - EXTEND outputs `rx_er`=1, `rxd`=0x0F, `rx_dv`=0.
  - /R/ stays in EXTEND; K28.5 goes to IDLE; /S/ goes to RECEIVE (packet burst).
  - Anything else outputs `rx_er`=1, `rxd`=0x1F for one cycle, then IDLE.
- Undefined: no EXTEND state. Consecutive /R/ after /T/ are absorbed silently in END_R.

## Test plan
- Reset, then sync=1 with K28.5, D5.6 repeated → IDLE; all outputs 0; `receiving`=0.
- Frame /S/, 0x55×6, 0xD5, 0x01..0x40, /T/, /R/, K28.5 → `rxd` 0x55 with `rx_dv`=1, then each octet in order; `rx_dv` drops the cycle after /T/ is sampled; `receiving` falls after K28.5.
- `cg_err` on the 10th data octet → that output cycle has `rx_dv`=1, `rx_er`=1; the frame continues normally.
- In IDLE, inject K30.7 → `rx_er`=1, `rxd`=0x0E, `receiving`=1 until the next K28.5.
- /T/ followed by D0.0 → `bad_end` high for exactly one cycle, state IDLE. Separately, drop `sync_status` mid-frame → one `rx_dv`=1, `rx_er`=1 cycle, then all outputs 0.
- /T/, /R/, /R/, /R/, K28.5, run with and without `PCS_RX_CARRIER_EXT_EN`:
  - With the macro: `rx_er`=1, `rxd`=0x0F for 2 cycles.
  - Without it: outputs stay 0.
  - In both cases `receiving` stays 1 until K28.5.

Source files
------------

// File: rtl/pcs_rx_sm_if.sv
// Code-group input bundle and GMII-style receive output bundle for pcs_rx_sm.
// master: decoder/test side driving code-groups. slave: the PCS receive FSM.
interface pcs_rx_sm_if;
    logic       sync_status;
    logic       cg_valid;
    logic [7:0] cg_data;
    logic       cg_is_k;
    logic       cg_err;
    logic [7:0] rxd;
    logic       rx_dv;
    logic       rx_er;
    logic       receiving;
    logic       bad_end;

    modport master (
        output sync_status, cg_valid, cg_data, cg_is_k, cg_err,
        input  rxd, rx_dv, rx_er, receiving, bad_end
    );

    modport slave (
        input  sync_status, cg_valid, cg_data, cg_is_k, cg_err,
        output rxd, rx_dv, rx_er, receiving, bad_end
    );
endinterface

// File: rtl/pcs_rx_sm.sv
// 1000BASE-X receive PCS state machine: decoded code-groups in, registered
// GMII rxd/rx_dv/rx_er plus receiving/bad_end out.
// Optional feature macro: PCS_RX_CARRIER_EXT_EN adds the EXTEND state
// (carrier extension after /T/ /R/ /R/).
module pcs_rx_sm (
    input  logic        clk,
    input  logic        reset,
    pcs_rx_sm_if.slave  bus
);

    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam logic [7:0] K_SOP   = 8'hFB;
    localparam logic [7:0] K_EOP   = 8'hFD;
    localparam logic [7:0] K_CEXT  = 8'hF7;

    typedef enum logic [2:0] {
        LINK_FAILED   = 3'd0,
        IDLE          = 3'd1,
        RECEIVE       = 3'd2,
        END_T         = 3'd3,
        END_R         = 3'd4,
`ifdef PCS_RX_CARRIER_EXT_EN
        EXTEND        = 3'd6,
`endif
        FALSE_CARRIER = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] rxd_q, rxd_d;
    logic       rx_dv_q, rx_dv_d;
    logic       rx_er_q, rx_er_d;
    logic       receiving_q, receiving_d;
    logic       bad_end_q, bad_end_d;

    // Code-group classification; cg_err overrides K/D so an errored /S/ or
    // K28.5 is never taken as a valid delimiter.
    logic raw_comma, is_comma, is_s, is_t, is_r, is_other_k, is_d;
    assign raw_comma  = bus.cg_is_k && (bus.cg_data == K_COMMA);
    assign is_comma   = raw_comma && !bus.cg_err;
    assign is_s       = bus.cg_is_k && !bus.cg_err && (bus.cg_data == K_SOP);
    assign is_t       = bus.cg_is_k && !bus.cg_err && (bus.cg_data == K_EOP);
    assign is_r       = bus.cg_is_k && !bus.cg_err && (bus.cg_data == K_CEXT);
    assign is_other_k = bus.cg_is_k && !bus.cg_err && !raw_comma && !is_s && !is_t && !is_r;
    assign is_d       = !bus.cg_is_k && !bus.cg_err;

    // States in which carrier is reported to the CRS logic.
    function automatic logic carrier_state(input state_t s);
        logic c;
        c = (s == RECEIVE) || (s == END_T) || (s == END_R) || (s == FALSE_CARRIER);
`ifdef PCS_RX_CARRIER_EXT_EN
        c = c || (s == EXTEND);
`endif
        return c;
    endfunction

    // State and output registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LINK_FAILED;
            rxd_q       <= 8'h00;
            rx_dv_q     <= 1'b0;
            rx_er_q     <= 1'b0;
            receiving_q <= 1'b0;
            bad_end_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rxd_q       <= rxd_d;
            rx_dv_q     <= rx_dv_d;
            rx_er_q     <= rx_er_d;
            receiving_q <= receiving_d;
            bad_end_q   <= bad_end_d;
        end
    end

    // Next-state: sync loss wins over everything, otherwise advance only on a
    // presented code-group.
    always_comb begin
        state_d = state_q;
        if (!bus.sync_status) begin
            state_d = LINK_FAILED;
        end else if (bus.cg_valid) begin
            case (state_q)
                LINK_FAILED:   if (raw_comma) state_d = IDLE;
                IDLE: begin
                    if (is_s)       state_d = RECEIVE;
                    else if (!is_d && !is_comma) state_d = FALSE_CARRIER;
                end
                FALSE_CARRIER: if (is_comma) state_d = IDLE;
                RECEIVE: begin
                    if (is_t)           state_d = END_T;
                    else if (is_comma)  state_d = IDLE;
                end
                END_T:         state_d = is_r ? END_R : IDLE;
                END_R: begin
`ifdef PCS_RX_CARRIER_EXT_EN
                    if (is_r)          state_d = EXTEND;
`else
                    if (is_r)          state_d = END_R;
`endif
                    else if (is_s)     state_d = RECEIVE;
                    else               state_d = IDLE;
                end
`ifdef PCS_RX_CARRIER_EXT_EN
                EXTEND: begin
                    if (is_r)          state_d = EXTEND;
                    else if (is_s)     state_d = RECEIVE;
                    else               state_d = IDLE;
                end
`endif
                default:               state_d = LINK_FAILED;
            endcase
        end
    end

    // Outputs for the code-group being consumed; idle cycles hold everything
    // but the bad_end pulse. receiving also covers any cycle that signals an
    // octet or error, so the carrier does not drop under an error cycle.
    always_comb begin
        rxd_d     = rxd_q;
        rx_dv_d   = rx_dv_q;
        rx_er_d   = rx_er_q;
        bad_end_d = 1'b0;
        if (!bus.sync_status) begin
            rxd_d   = 8'h00;
            rx_dv_d = 1'b0;
            rx_er_d = 1'b0;
            if (state_q == RECEIVE) begin
                rxd_d   = bus.cg_data;
                rx_dv_d = 1'b1;
                rx_er_d = 1'b1;
            end
        end else if (bus.cg_valid) begin
            rxd_d   = 8'h00;
            rx_dv_d = 1'b0;
            rx_er_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_s) begin
                        rxd_d   = 8'h55;
                        rx_dv_d = 1'b1;
                    end else if (!is_d && !is_comma) begin
                        rxd_d   = 8'h0E;
                        rx_er_d = 1'b1;
                    end
                end
                FALSE_CARRIER: begin
                    if (!is_comma) begin
                        rxd_d   = 8'h0E;
                        rx_er_d = 1'b1;
                    end
                end
                RECEIVE: begin
                    if (!is_t) begin
                        rxd_d   = bus.cg_data;
                        rx_dv_d = 1'b1;
                        rx_er_d = !is_d;
                    end
                end
                END_T:         bad_end_d = !is_r;
                END_R: begin
`ifdef PCS_RX_CARRIER_EXT_EN
                    if (is_r) begin
                        rxd_d   = 8'h0F;
                        rx_er_d = 1'b1;
                    end else
`endif
                    if (is_s) begin
                        rxd_d   = 8'h55;
                        rx_dv_d = 1'b1;
                    end
                end
`ifdef PCS_RX_CARRIER_EXT_EN
                EXTEND: begin
                    if (is_r) begin
                        rxd_d   = 8'h0F;
                        rx_er_d = 1'b1;
                    end else if (is_s) begin
                        rxd_d   = 8'h55;
                        rx_dv_d = 1'b1;
                    end else if (!is_comma) begin
                        rxd_d   = 8'h1F;
                        rx_er_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
        receiving_d = receiving_q;
        if (!bus.sync_status || bus.cg_valid)
            receiving_d = carrier_state(state_d) || rx_dv_d || rx_er_d;
    end

    assign bus.rxd       = rxd_q;
    assign bus.rx_dv     = rx_dv_q;
    assign bus.rx_er     = rx_er_q;
    assign bus.receiving = receiving_q;
    assign bus.bad_end   = bad_end_q;

endmodule

// File: tb/tb_pcs_rx_sm.sv
// Self-checking bench for pcs_rx_sm: each test builds a stimulus table with
// the expected registered outputs, drives it one code-group per cycle through a
// scoreboard queue and compares after the clock edge.
module tb_pcs_rx_sm;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pcs_rx_sm_if bus();
    pcs_rx_sm dut (.clk(clk), .reset(reset), .bus(bus.slave));

    localparam logic [7:0] KC = 8'hBC, KS = 8'hFB, KT = 8'hFD, KR = 8'hF7;
    localparam logic [7:0] K307 = 8'hFE, D56 = 8'hC5;
    // packed outputs: {rxd, rx_dv, rx_er, receiving, bad_end}
    localparam logic [11:0] Z   = 12'h000;
    localparam logic [11:0] SOP = {8'h55, 4'b1010};
    localparam logic [11:0] TT  = {8'h00, 4'b0010};
    localparam logic [11:0] FC  = {8'h0E, 4'b0110};
    localparam logic [11:0] BE  = {8'h00, 4'b0001};
    localparam logic [11:0] EXT = {8'h0F, 4'b0110};

    typedef struct {
        logic v, k, e, s, r;
        logic [7:0] d;
        logic [11:0] x, m;
    } stim_t;

    stim_t       st[$];
    logic [11:0] sb[$];
    int total = 0;
    int bad = 0;

    function automatic logic [11:0] dat(input logic [7:0] d, input logic er);
        return {d, 1'b1, er, 1'b1, 1'b0};
    endfunction

    function automatic logic [11:0] outs();
        return {bus.rxd, bus.rx_dv, bus.rx_er, bus.receiving, bus.bad_end};
    endfunction

    task automatic add(input logic v, input logic k, input logic [7:0] d, input logic e,
                       input logic [11:0] x, input logic s = 1'b1, input logic r = 1'b0,
                       input logic [11:0] m = 12'hFFF);
        stim_t t;
        t.v = v; t.k = k; t.d = d; t.e = e; t.x = x; t.s = s; t.r = r; t.m = m;
        st.push_back(t);
    endtask

    // Drive one code-group, record its expected response, and step past the edge.
    task automatic cyc(input stim_t t);
        reset           = t.r;
        bus.sync_status = t.s;
        bus.cg_valid    = t.v;
        bus.cg_is_k     = t.k;
        bus.cg_data     = t.d;
        bus.cg_err      = t.e;
        sb.push_back(t.x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] x;
        st.delete();
        add(1, 1, KS, 0, Z, 1, 1);
        add(1, 0, 8'hA5, 1, Z, 1, 1);
        add(1, 1, KS, 0, Z, 0, 1);
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if (outs() !== x) begin
                bad++;
                $display("FAIL reset[%0d] got %h want %h", i, outs(), x);
            end
        end
    endtask

    task automatic test_idle();
        logic [11:0] x;
        st.delete();
        add(1, 0, 8'h00, 0, Z);        // LINK_FAILED ignores data
        add(1, 1, KS, 0, Z);           // and /S/
        add(1, 1, KC, 1, Z);           // comma with cg_err still accepted here
        for (int i = 0; i < 3; i++) begin
            add(1, 0, D56, 0, Z);
            add(1, 1, KC, 0, Z);
        end
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if (outs() !== x) begin
                bad++;
                $display("FAIL idle[%0d] got %h want %h", i, outs(), x);
            end
        end
    endtask

    task automatic test_frame();
        logic [11:0] x;
        st.delete();
        add(1, 1, KS, 0, SOP);
        for (int i = 0; i < 6; i++) add(1, 0, 8'h55, 0, SOP);
        add(1, 0, 8'hD5, 0, dat(8'hD5, 0));
        for (int n = 1; n <= 64; n++)
            add(1, 0, 8'(n), (n == 10), dat(8'(n), (n == 10)));
        add(1, 1, KT, 0, TT);
        add(1, 1, KR, 0, TT);
        add(1, 1, KC, 0, Z);
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if (outs() !== x) begin
                bad++;
                $display("FAIL frame[%0d] got %h want %h", i, outs(), x);
            end
        end
    endtask

    task automatic test_false_carrier();
        logic [11:0] x;
        st.delete();
        add(1, 1, K307, 0, FC);
        add(1, 0, 8'h12, 0, FC);
        add(1, 0, 8'h34, 1, FC);
        add(1, 1, KC, 1, FC);          // errored comma does not end false carrier
        add(1, 1, KC, 0, Z);
        add(1, 0, D56, 0, Z);
        add(1, 0, D56, 1, FC);         // cg_err in IDLE
        add(1, 1, KC, 0, Z);
        add(1, 1, KT, 0, FC);          // stray /T/ in IDLE
        add(1, 1, KC, 0, Z);
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if (outs() !== x) begin
                bad++;
                $display("FAIL false_carrier[%0d] got %h want %h", i, outs(), x);
            end
        end
    endtask

    task automatic test_bad_end();
        logic [11:0] x;
        st.delete();
        add(1, 1, KS, 0, SOP);
        add(1, 0, 8'hAA, 0, dat(8'hAA, 0));
        add(1, 1, KT, 0, TT);
        add(1, 0, 8'h00, 0, BE);
        add(1, 0, D56, 0, Z);
        add(1, 1, KS, 0, SOP);
        add(1, 1, KT, 0, TT);
        add(1, 1, KC, 0, BE);          // comma after /T/ is also a bad end
        add(1, 0, D56, 0, Z);
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if (outs() !== x) begin
                bad++;
                $display("FAIL bad_end[%0d] got %h want %h", i, outs(), x);
            end
        end
    endtask

    task automatic test_sync_loss();
        logic [11:0] x;
        st.delete();
        add(1, 1, KS, 0, SOP);
        add(1, 0, 8'h33, 0, dat(8'h33, 0));
        add(1, 0, 8'h44, 0, {8'h00, 4'b1100}, 0, 0, 12'h00D);
        add(1, 0, 8'h55, 0, Z, 0);
        add(1, 0, D56, 0, Z);
        add(1, 1, KS, 0, Z);           // still LINK_FAILED
        add(1, 1, KC, 0, Z);
        add(1, 1, KS, 0, SOP);
        add(1, 1, KT, 0, TT);
        add(1, 1, KR, 0, TT);
        add(1, 1, KC, 0, Z);
        add(1, 1, K307, 0, FC);
        add(1, 1, K307, 0, Z, 0);      // sync loss outside RECEIVE: all zero
        add(1, 1, KC, 0, Z);
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if ((outs() & st[i].m) !== (x & st[i].m)) begin
                bad++;
                $display("FAIL sync_loss[%0d] got %h want %h", i, outs() & st[i].m, x & st[i].m);
            end
        end
    endtask

    task automatic test_extend();
        logic [11:0] x;
        st.delete();
        add(1, 1, KS, 0, SOP);
        add(1, 0, 8'h9A, 0, dat(8'h9A, 0));
        add(1, 1, KT, 0, TT);
        add(1, 1, KR, 0, TT);
`ifdef PCS_RX_CARRIER_EXT_EN
        add(1, 1, KR, 0, EXT);
        add(1, 1, KR, 0, EXT);
        add(1, 1, KC, 0, Z);
        add(1, 1, KS, 0, SOP);
        add(1, 1, KT, 0, TT);
        add(1, 1, KR, 0, TT);
        add(1, 1, KR, 0, EXT);
        add(1, 0, 8'h00, 0, {8'h1F, 4'b0110});
        add(1, 0, D56, 0, Z);
`else
        add(1, 1, KR, 0, TT);
        add(1, 1, KR, 0, TT);
        add(1, 1, KC, 0, Z);
`endif
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if (outs() !== x) begin
                bad++;
                $display("FAIL extend[%0d] got %h want %h", i, outs(), x);
            end
        end
    endtask

    task automatic test_valid_hold();
        logic [11:0] x;
        st.delete();
        add(1, 1, KS, 0, SOP);
        add(1, 0, 8'h77, 0, dat(8'h77, 0));
        add(0, 1, KT, 0, dat(8'h77, 0));
        add(0, 1, KC, 1, dat(8'h77, 0));
        add(1, 1, KT, 0, TT);
        add(0, 1, KS, 0, TT);
        add(1, 0, 8'h00, 0, BE);
        add(0, 1, K307, 0, Z);         // bad_end drops, idle code ignored
        add(1, 0, D56, 0, Z);
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if (outs() !== x) begin
                bad++;
                $display("FAIL valid_hold[%0d] got %h want %h", i, outs(), x);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] x;
        st.delete();
        add(1, 1, KS, 0, SOP);
        add(1, 0, 8'h11, 0, dat(8'h11, 0));
        add(1, 1, KT, 0, TT);
        add(1, 1, KR, 0, TT);
        add(1, 1, KS, 0, SOP);
        add(1, 0, 8'h22, 0, dat(8'h22, 0));
        add(1, 1, KR, 0, dat(8'hF7, 1)); // /R/ inside a frame is an error octet
        add(1, 1, KT, 0, TT);
        add(1, 1, KR, 0, TT);
        add(1, 1, KC, 0, Z);
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if (outs() !== x) begin
                bad++;
                $display("FAIL back_to_back[%0d] got %h want %h", i, outs(), x);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] x;
        st.delete();
        add(1, 1, KS, 0, SOP);
        add(1, 0, 8'h66, 0, dat(8'h66, 0));
        add(1, 0, 8'h77, 0, Z, 1, 1);
        add(1, 0, 8'h88, 0, Z);
        add(1, 1, KS, 0, Z);
        add(1, 1, KC, 0, Z);
        add(1, 1, KS, 0, SOP);
        add(1, 1, KC, 0, dat(8'hBC, 1)); // early end
        add(1, 0, D56, 0, Z);
        foreach (st[i]) begin
            cyc(st[i]);
            x = sb.pop_front();
            total++;
            if (outs() !== x) begin
                bad++;
                $display("FAIL reset_mid[%0d] got %h want %h", i, outs(), x);
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.sync_status = 1'b0;
        bus.cg_valid    = 1'b0;
        bus.cg_is_k     = 1'b0;
        bus.cg_data     = 8'h00;
        bus.cg_err      = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_idle();
        test_frame();
        test_false_carrier();
        test_bad_end();
        test_sync_loss();
        test_extend();
        test_valid_hold();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
